hk_spi_responder: RTL and testbench

HK_SPI_RESPONDER -- requirements
Module: hk_spi_responder

---
 rtl/hk_spi_responder.sv | 179 +++++++++++++++++
 tb/tb_hk_spi_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hk_spi_responder.sv
// SPI mode-0 responder bridging a pad-level SPI port onto an 8-bit register bus.
// All pad inputs are oversampled on wb_clk_i; addresses auto-increment across streamed bytes.
module hk_spi_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       spi_sck,
   input  logic       spi_csb,
   input  logic       spi_sdi,
   output logic       spi_sdo,
   output logic       spi_sdo_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, sel_sync, sdi_sync;
   logic                   sck_s, sel_s, sdi_s;
   logic                   sck_d, sel_d;
   logic [2:0]             warm_cnt;
   logic                   warm_done, armed;
   logic                   sck_rise, sck_fall, cs_fall;

   logic [2:0] bit_cnt;
   logic [6:0] rx_sh;
   logic [7:0] rx_byte;
   logic       byte_done;
   logic       cmd_ok;
   logic       mode_rd, mode_wr, ignore;
   logic       cmd_load, addr_load, data_done;
   logic       rd_cap;
   logic [7:0] tx_sh;
   logic       sdo_q;

   assign sck_s = sck_sync[SYNC_STAGES-1];
   assign sel_s = sel_sync[SYNC_STAGES-1];
   assign sdi_s = sdi_sync[SYNC_STAGES-1];

   assign sck_rise  = sck_s & ~sck_d;
   assign sck_fall  = ~sck_s & sck_d;
   assign warm_done = (warm_cnt == 3'(SYNC_STAGES));
   // A select that is already active when reset releases must not open a transaction.
   assign cs_fall   = sel_s & ~sel_d & armed;

   assign rx_byte   = {rx_sh, sdi_s};
   assign byte_done = sck_rise && (bit_cnt == 3'd7);
   assign cmd_ok    = (rx_byte == 8'h40) || (rx_byte == 8'h80) || (rx_byte == 8'hC0);

   assign busy       = sel_s;
   assign spi_sdo_oe = (state == DATA) && mode_rd;
   assign spi_sdo    = sdo_q & spi_sdo_oe;

   // Input synchronizers; chip select is carried inverted so reset clears it to "deselected"
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sck_sync <= '0;
         sel_sync <= '0;
         sdi_sync <= '0;
         sck_d    <= 1'b0;
         sel_d    <= 1'b0;
         warm_cnt <= 3'd0;
         armed    <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         sel_sync <= {sel_sync[SYNC_STAGES-2:0], ~spi_csb};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
         sck_d    <= sck_s;
         sel_d    <= sel_s;
         if (!warm_done)
            warm_cnt <= warm_cnt + 3'd1;
         if (warm_done && !sel_s)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_load  = 1'b0;
      addr_load = 1'b0;
      data_done = 1'b0;
      case (state)
         IDLE: if (cs_fall) state_nxt = CMD;
         CMD: begin
            if (byte_done && !ignore) begin
               cmd_load = 1'b1;
               if (cmd_ok)
                  state_nxt = ADDR;
            end
         end
         ADDR: begin
            if (byte_done) begin
               addr_load = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: if (byte_done) data_done = 1'b1;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && !sel_s) begin
         state_nxt = IDLE;
         cmd_load  = 1'b0;
         addr_load = 1'b0;
         data_done = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         bit_cnt   <= 3'd0;
         rx_sh     <= 7'd0;
         mode_rd   <= 1'b0;
         mode_wr   <= 1'b0;
         ignore    <= 1'b0;
         reg_addr  <= 8'd0;
         reg_wdata <= 8'd0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         rd_cap    <= 1'b0;
         tx_sh     <= 8'd0;
         sdo_q     <= 1'b0;
      end else begin
         if (state_nxt == IDLE) begin
            bit_cnt <= 3'd0;
            mode_rd <= 1'b0;
            mode_wr <= 1'b0;
            ignore  <= 1'b0;
         end else begin
            if (sck_rise) begin
               bit_cnt <= bit_cnt + 3'd1;
               rx_sh   <= rx_byte[6:0];
            end
            if (cmd_load) begin
               mode_rd <= rx_byte[6] & cmd_ok;
               mode_wr <= rx_byte[7] & cmd_ok;
               ignore  <= ~cmd_ok;
            end
         end

         // Write commits first; the read fetch always follows at the advanced address.
         reg_we <= data_done & mode_wr;
         reg_re <= (addr_load & mode_rd) | (data_done & mode_rd & ~mode_wr) | (reg_we & mode_rd);
         rd_cap <= reg_re;

         if (data_done && mode_wr)
            reg_wdata <= rx_byte;

         if (addr_load)
            reg_addr <= rx_byte;
         else if ((data_done && !mode_wr) || reg_we)
            reg_addr <= reg_addr + 8'd1;

         if (rd_cap)
            tx_sh <= reg_rdata;
         else if (sck_fall && spi_sdo_oe)
            tx_sh <= {tx_sh[6:0], 1'b0};

         if (!spi_sdo_oe)
            sdo_q <= 1'b0;
         else if (sck_fall)
            sdo_q <= tx_sh[7];
      end
   end

endmodule

// File: tb/tb_hk_spi_responder.sv
// Randomized SPI transactions checked against a transaction-level model of expected
// register-bus strobes and read-back bytes.
module tb_hk_spi_responder;

   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       rst, sck, csb, sdi;
   logic       sdo, sdo_oe;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, reg_re, busy;

   always #5 clk = ~clk;

   hk_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .spi_sck   (sck),
      .spi_csb   (csb),
      .spi_sdi   (sdi),
      .spi_sdo   (sdo),
      .spi_sdo_oe(sdo_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        cur_ev;
   logic [7:0] mem [256];
   logic [7:0] tx_data [8];
   logic [7:0] m_addr;
   logic [7:0] first_rd;
   int         half;
   int         n_checks = 0;
   int         n_err = 0;

   task automatic check(input logic ok, input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // Register-file read port plus per-cycle strobe scoreboard.
   always @(negedge clk) begin
      if (reg_re) reg_rdata = mem[reg_addr];
      if (!rst) begin
         if (reg_we || reg_re) begin
            check(!(reg_we && reg_re), "we_re_overlap", {30'd0, reg_we, reg_re}, 32'd0);
            check(exp_q.size() != 0, "unexpected_strobe", {22'd0, reg_we, reg_re, reg_addr}, 32'd0);
            if (exp_q.size() != 0) begin
               cur_ev = exp_q.pop_front();
               check(reg_we == cur_ev.we, "strobe_kind", {31'd0, reg_we}, {31'd0, cur_ev.we});
               check(reg_addr == cur_ev.addr, "strobe_addr", {24'd0, reg_addr}, {24'd0, cur_ev.addr});
               if (cur_ev.we)
                  check(reg_wdata == cur_ev.data, "strobe_wdata", {24'd0, reg_wdata}, {24'd0, cur_ev.data});
            end
         end
         if (!sdo_oe)
            check(sdo == 1'b0, "sdo_while_disabled", {31'd0, sdo}, 32'd0);
      end
   end

   // chk: 0 = output must stay disabled, 1 = must drive exp_rd MSB first, 2 = unchecked
   task automatic xfer(input logic [7:0] tx, input int nbits, input int chk,
                       input logic [7:0] exp_rd, output logic [7:0] got);
      logic oe_all, oe_any;
      oe_all = 1'b1;
      oe_any = 1'b0;
      got    = 8'd0;
      for (int b = 0; b < nbits; b++) begin
         sdi = tx[7-b];
         repeat (half) @(posedge clk);
         #1;
         got[7-b] = sdo;
         oe_all   = oe_all & sdo_oe;
         oe_any   = oe_any | sdo_oe;
         sck = 1'b1;
         repeat (half) @(posedge clk);
         #1;
         sck = 1'b0;
      end
      if (chk == 1) begin
         check(oe_all, "oe_during_read", {31'd0, oe_all}, 32'd1);
         check(got == exp_rd, "sdo_byte", {24'd0, got}, {24'd0, exp_rd});
      end else if (chk == 0) begin
         check(!oe_any && got == 8'd0, "sdo_disabled", {23'd0, oe_any, got}, 32'd0);
      end
   endtask

   task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int nfull, input int nbits);
      logic       valid, rd, wr;
      logic [7:0] a, ra, got;
      valid = (cmd == 8'h40) || (cmd == 8'h80) || (cmd == 8'hC0);
      rd    = valid && cmd[6];
      wr    = valid && cmd[7];
      a     = addr;
      if (rd) exp_q.push_back('{1'b0, a, 8'd0});
      for (int i = 0; i < nfull; i++) begin
         if (wr) exp_q.push_back('{1'b1, a, tx_data[i]});
         a = a + 8'd1;
         if (rd) exp_q.push_back('{1'b0, a, 8'd0});
      end
      if (valid) m_addr = a;

      csb = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check(busy == 1'b1, "busy_after_select", {31'd0, busy}, 32'd1);
      xfer(cmd, 8, 0, 8'd0, got);
      xfer(addr, 8, 0, 8'd0, got);
      for (int i = 0; i < nfull; i++) begin
         ra = addr + 8'(i);
         xfer(tx_data[i], 8, rd ? 1 : 0, mem[ra], got);
         if (i == 0) first_rd = got;
      end
      if (nbits > 0) xfer(tx_data[nfull], nbits, rd ? 2 : 0, 8'd0, got);
      repeat (5) @(posedge clk);
      #1;
      check(busy == 1'b1, "busy_held", {31'd0, busy}, 32'd1);
      csb = 1'b1;
      repeat (SYNC_STAGES + 2) @(posedge clk);
      #1;
      check(busy == 1'b0, "busy_released", {31'd0, busy}, 32'd0);
      check(sdo_oe == 1'b0, "oe_released", {31'd0, sdo_oe}, 32'd0);
      check(exp_q.size() == 0, "missing_strobe", exp_q.size(), 32'd0);
      exp_q.delete();
      check(reg_addr == m_addr, "final_addr", {24'd0, reg_addr}, {24'd0, m_addr});
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string nm);
      check({sdo, sdo_oe, reg_we, reg_re, busy} == 5'd0, nm, {27'd0, sdo, sdo_oe, reg_we, reg_re, busy}, 32'd0);
      check(reg_addr == 8'd0 && reg_wdata == 8'd0, nm, {16'd0, reg_addr, reg_wdata}, 32'd0);
   endtask

   initial begin
      logic [7:0] c, g;
      int         s, nf, nb;
      rst = 1'b1; sck = 1'b0; csb = 1'b1; sdi = 1'b0; reg_rdata = 8'd0;
      half = 5;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[3] = 8'h20;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      rst = 1'b0;
      m_addr = 8'd0;
      repeat (6) @(posedge clk);
      #1;

      run_txn(8'h40, 8'h03, 1, 0);
      check(first_rd == 8'h20, "read_addr03", {24'd0, first_rd}, 32'h20);

      tx_data[0] = 8'h01;
      run_txn(8'h80, 8'h0B, 1, 0);
      check(reg_addr == 8'h0C, "write_addr_inc", {24'd0, reg_addr}, 32'h0C);
      check(reg_wdata == 8'h01, "write_data", {24'd0, reg_wdata}, 32'h01);

      tx_data[0] = 8'hAA; tx_data[1] = 8'h55;
      run_txn(8'h80, 8'hFF, 2, 0);
      check(reg_wdata == 8'h55, "wrap_data", {24'd0, reg_wdata}, 32'h55);
      check(reg_addr == 8'h01, "wrap_addr", {24'd0, reg_addr}, 32'h01);

      tx_data[0] = 8'h00;
      run_txn(8'hC2, 8'h03, 1, 0);

      tx_data[0] = 8'hFF;
      run_txn(8'h80, 8'h10, 0, 5);
      run_txn(8'h40, 8'h10, 1, 0);

      for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
      run_txn(8'hC0, 8'h7E, 3, 0);

      for (int k = 0; k < 10; k++) begin
         s = $urandom_range(0, 3);
         if (s == 0) c = 8'h40;
         else if (s == 1) c = 8'h80;
         else if (s == 2) c = 8'hC0;
         else begin
            c = 8'($urandom);
            while (c == 8'h40 || c == 8'h80 || c == 8'hC0) c = 8'($urandom);
         end
         nf = $urandom_range(0, 3);
         nb = $urandom_range(0, 7);
         for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
         half = $urandom_range(4, 7);
         run_txn(c, 8'($urandom), nf, nb);
      end

      // Reset in the middle of a read data byte, with select left low afterwards.
      half = 5;
      exp_q.push_back('{1'b0, 8'h21, 8'd0});
      csb = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      xfer(8'h40, 8, 0, 8'd0, g);
      xfer(8'h21, 8, 0, 8'd0, g);
      xfer(8'h00, 4, 2, 8'd0, g);
      check(exp_q.size() == 0, "fetch_before_reset", exp_q.size(), 32'd0);
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("reset_mid_read");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_addr = 8'd0;
      xfer(8'h40, 8, 0, 8'd0, g);
      xfer(8'h21, 8, 0, 8'd0, g);
      xfer(8'h5A, 8, 0, 8'd0, g);
      check(reg_addr == 8'd0, "no_txn_after_reset", {24'd0, reg_addr}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      csb = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      run_txn(8'h40, 8'h21, 2, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
